// File: rtl/baud_gen_os_if.sv
// ============================================================================
// Module      : baud_gen_os_if
// Description : Control/strobe bundle between the baud generator (slave) and
//               its controller / UART consumers (master). The fractional
//               divisor input exists only when BAUD_FRAC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baud_gen_os_if #(
  parameter int DIV_W  = 24,
  parameter int FRAC_W = 8
);
  logic              en;
  logic              div_wr;
  logic [DIV_W-1:0]  div_in;
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac_in;
`endif
  logic              div_ack;
  logic [DIV_W-1:0]  div_cur;
  logic              os_tick;
  logic              baud_tick;
  logic              bclk;

  modport master (
    output en, div_wr, div_in,
`ifdef BAUD_FRAC_EN
    output div_frac_in,
`endif
    input  div_ack, div_cur, os_tick, baud_tick, bclk
  );

  modport slave (
    input  en, div_wr, div_in,
`ifdef BAUD_FRAC_EN
    input  div_frac_in,
`endif
    output div_ack, div_cur, os_tick, baud_tick, bclk
  );
endinterface

`default_nettype wire

// File: rtl/baud_gen_os.sv
// ============================================================================
// Module      : baud_gen_os
// Description : Runtime-programmable baud generator. Produces an oversample
//               strobe (os_tick), a baud strobe (baud_tick) and a 50%-duty
//               baud clock (bclk). Divisor writes are held pending and only
//               copied in at an os period boundary so no period is cut short.
//               Optional macro BAUD_FRAC_EN adds a fractional divisor with a
//               phase accumulator that stretches selected periods by 1 clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_gen_os #(
  parameter int SYS_CLK      = 100_000_000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,   // must be even and >= 2
  parameter int DIV_W        = 24,
  parameter int FRAC_W       = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  baud_gen_os_if.slave  bus
);

  localparam int               D_RST_I = SYS_CLK / (DEFAULT_BAUD * OVERSAMPLE);
  localparam logic [DIV_W-1:0] D_RST   = (D_RST_I < 1) ? DIV_W'(1) : DIV_W'(D_RST_I);
  localparam int               BD_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [BD_W-1:0]  BD_LAST = BD_W'(OVERSAMPLE - 1);
  localparam logic [BD_W-1:0]  BD_HALF = BD_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] r_os_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_pend_div;
  logic [BD_W-1:0]  r_bd_cnt;
  logic             r_pending;
  logic             r_os_tick;
  logic             r_baud_tick;
  logic             r_bclk;
  logic             r_div_ack;

  logic [DIV_W:0]   w_period;     // length of the current os period in clks
  logic             w_wrap;       // this edge ends the current os period
  logic             w_apply;      // this edge copies the pending divisor
  logic [BD_W-1:0]  w_bd_next;
  logic [DIV_W-1:0] w_div_in_fix; // a zero divisor is meaningless, store 1

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_pend_frac;
  logic [FRAC_W-1:0] r_frac_cur;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;     // current period is stretched by one clk
  logic [FRAC_W:0]   w_acc_sum;

  assign w_period  = {1'b0, r_div_cur} + {{DIV_W{1'b0}}, r_extra};
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_cur};
`else
  assign w_period  = {1'b0, r_div_cur};
`endif

  assign w_wrap       = bus.en && (({1'b0, r_os_cnt} + {{DIV_W{1'b0}}, 1'b1}) == w_period);
  assign w_apply      = r_pending && (w_wrap || !bus.en);
  assign w_bd_next    = (r_bd_cnt == BD_LAST) ? '0 : r_bd_cnt + BD_W'(1);
  assign w_div_in_fix = (bus.div_in == '0) ? DIV_W'(1) : bus.div_in;

  // Oversample/baud counters, strobes and bclk; all cleared while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt    <= '0;
      r_bd_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
      r_bclk      <= 1'b1;
    end else if (!bus.en) begin
      r_os_cnt    <= '0;
      r_bd_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
      r_bclk      <= 1'b1;
    end else begin
      r_os_tick   <= w_wrap;
      r_baud_tick <= w_wrap && (r_bd_cnt == BD_LAST);
      if (w_wrap) begin
        r_os_cnt <= '0;
        r_bd_cnt <= w_bd_next;
        if ((w_bd_next == BD_HALF) || (w_bd_next == BD_LAST)) begin
          r_bclk <= ~r_bclk;
        end
      end else begin
        r_os_cnt <= r_os_cnt + DIV_W'(1);
      end
    end
  end

  // Pending divisor register and glitch-free hand-over into div_cur
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cur  <= D_RST;
      r_pend_div <= D_RST;
      r_pending  <= 1'b0;
      r_div_ack  <= 1'b0;
    end else begin
      r_div_ack <= w_apply;
      if (w_apply) begin
        r_div_cur <= r_pend_div;
      end
      // A write landing on the apply edge refills pending for the next wrap
      if (bus.div_wr) begin
        r_pend_div <= w_div_in_fix;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending  <= 1'b0;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  // Fraction register and phase accumulator; a carry stretches the next period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_frac <= '0;
      r_frac_cur  <= '0;
      r_acc       <= '0;
      r_extra     <= 1'b0;
    end else begin
      if (bus.div_wr) begin
        r_pend_frac <= bus.div_frac_in;
      end
      if (w_apply) begin
        r_frac_cur <= r_pend_frac;
      end
      if (!bus.en || w_apply) begin
        r_acc   <= '0;
        r_extra <= 1'b0;
      end else if (w_wrap) begin
        r_acc   <= w_acc_sum[FRAC_W-1:0];
        r_extra <= w_acc_sum[FRAC_W];
      end
    end
  end
`endif

  assign bus.div_ack   = r_div_ack;
  assign bus.div_cur   = r_div_cur;
  assign bus.os_tick   = r_os_tick;
  assign bus.baud_tick = r_baud_tick;
  assign bus.bclk      = r_bclk;

endmodule

`default_nettype wire

// File: tb/tb_baud_gen_os.sv
// ============================================================================
// Module      : tb_baud_gen_os
// Description : Self-checking bench for baud_gen_os. Expected strobe timing is
//               computed from divisor arithmetic and a transaction-level model
//               of pending/apply behaviour. BAUD_FRAC_EN enables the
//               fractional-divisor scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_baud_gen_os;
  localparam int DIV_W  = 24;
  localparam int FRAC_W = 8;
  localparam int OS     = 16;
  localparam int D_RST  = 651;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  baud_gen_os_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  baud_gen_os #(
    .SYS_CLK(100_000_000), .DEFAULT_BAUD(9600), .OVERSAMPLE(OS),
    .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // load a divisor while disabled; it applies on the following clock
  task automatic set_div(input int d, input int frac);
    bus.en = 1'b0;
    step();
    bus.div_wr = 1'b1;
    bus.div_in = DIV_W'(d);
`ifdef BAUD_FRAC_EN
    bus.div_frac_in = FRAC_W'(frac);
`else
    if (frac != 0) $display("note: fraction ignored in this build");
`endif
    step();
    bus.div_wr = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.div_wr = 1'b0; bus.div_in = '0;
`ifdef BAUD_FRAC_EN
    bus.div_frac_in = '0;
`endif
    repeat (3) step();
    checks++;
    if (bus.div_cur !== DIV_W'(D_RST)) begin
      errors++; $display("FAIL reset_div_cur: got %0d expected %0d", bus.div_cur, D_RST);
    end
    checks++;
    if ({bus.os_tick, bus.baud_tick, bus.div_ack, bus.bclk} !== 4'b0001) begin
      errors++; $display("FAIL reset_outputs: got os/bd/ack/bclk=%b%b%b%b expected 0001",
                         bus.os_tick, bus.baud_tick, bus.div_ack, bus.bclk);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.os_tick, bus.baud_tick, bus.bclk} !== 3'b001) begin
      errors++; $display("FAIL idle_disabled: got os/bd/bclk=%b%b%b expected 001",
                         bus.os_tick, bus.baud_tick, bus.bclk);
    end
  endtask

  task automatic test_default();
    int n, ticks, first, bd_at, bd_cyc;
    logic bclk7;
    n = 0; ticks = 0; first = 0; bd_at = 0; bd_cyc = 0; bclk7 = 1'b1;
    bus.en = 1'b1;
    while (n < OS * D_RST + 20 && bd_at == 0) begin
      step(); n++;
      if (bus.os_tick === 1'b1) begin
        ticks++;
        if (ticks == 1) first = n;
        if (ticks == 7) bclk7 = bus.bclk;
      end
      if (bus.baud_tick === 1'b1) begin bd_at = ticks; bd_cyc = n; end
    end
    checks++;
    if (first != D_RST) begin
      errors++; $display("FAIL default_first_os: got %0d expected %0d", first, D_RST);
    end
    checks++;
    if (bd_at != OS || bd_cyc != OS * D_RST) begin
      errors++; $display("FAIL default_first_baud: got tick#%0d cyc %0d expected tick#%0d cyc %0d",
                         bd_at, bd_cyc, OS, OS * D_RST);
    end
    checks++;
    if (bclk7 !== 1'b0 || bus.bclk !== 1'b1) begin
      errors++; $display("FAIL default_bclk: got %b/%b expected 0/1", bclk7, bus.bclk);
    end
    bus.en = 1'b0;
    step();
  endtask

  // fixed divisor: ticks at multiples of d, baud at multiples of OS*d,
  // bclk low when floor(t/d)+1 lies in an odd half-baud window
  task automatic test_fixed_div(input int d);
    int ed, j;
    logic [3:0] exp_v;
    ed = (d == 0) ? 1 : d;
    bus.en = 1'b0;
    step();
    bus.div_wr = 1'b1; bus.div_in = DIV_W'(d);
    step();
    bus.div_wr = 1'b0;
    checks++;
    if (bus.div_ack !== 1'b0) begin
      errors++; $display("FAIL fixed_ack_early d=%0d: got %b expected 0", d, bus.div_ack);
    end
    step();
    checks++;
    if (bus.div_ack !== 1'b1 || bus.div_cur !== DIV_W'(ed)) begin
      errors++; $display("FAIL fixed_apply d=%0d: got ack=%b cur=%0d expected ack=1 cur=%0d",
                         d, bus.div_ack, bus.div_cur, ed);
    end
    bus.en = 1'b1;
    for (int t = 1; t <= 2 * OS * ed + 3; t++) begin
      step();
      j = t / ed;
      exp_v = {(t % ed) == 0, (t % (OS * ed)) == 0, (((j + 1) / (OS / 2)) % 2) == 0, 1'b0};
      checks++;
      if ({bus.os_tick, bus.baud_tick, bus.bclk, bus.div_ack} !== exp_v) begin
        errors++; $display("FAIL fixed_run d=%0d t=%0d: got os/bd/bclk/ack=%b%b%b%b expected %b",
                           ed, t, bus.os_tick, bus.baud_tick, bus.bclk, bus.div_ack, exp_v);
      end
    end
    bus.en = 1'b0;
    step();
  endtask

  // mode 0: random writes; 1: write 10 mid-period; 2: writes 6 then 8 in one period
  task automatic test_writes(input int mode, input int d0, input int tlen);
    int cur, pend, nxt, val, acks;
    bit pv, wr, e_os, e_ack;
    set_div(d0, 0);
    cur = d0; pend = 0; pv = 0; nxt = d0; acks = 0;
    bus.en = 1'b1;
    for (int t = 1; t <= tlen; t++) begin
      wr = 0; val = 0;
      case (mode)
        0:       begin wr = ($urandom_range(0, 11) == 0); val = $urandom_range(0, 9); end
        1:       if (t == 6) begin wr = 1; val = 10; end
        default: if (t == 5) begin wr = 1; val = 6; end
                 else if (t == 7) begin wr = 1; val = 8; end
      endcase
      bus.div_wr = wr; bus.div_in = DIV_W'(val);
      step();
      e_os = 0; e_ack = 0;
      if (t == nxt) begin
        e_os = 1;
        if (pv) begin cur = pend; pv = 0; e_ack = 1; end
        nxt = t + cur;
      end
      if (wr) begin pend = (val == 0) ? 1 : val; pv = 1; end
      if (bus.div_ack === 1'b1) acks++;
      checks++;
      if (bus.os_tick !== e_os || bus.div_ack !== e_ack || bus.div_cur !== DIV_W'(cur)) begin
        errors++; $display("FAIL writes m%0d t=%0d: got os=%b ack=%b cur=%0d expected os=%b ack=%b cur=%0d",
                           mode, t, bus.os_tick, bus.div_ack, bus.div_cur, e_os, e_ack, cur);
      end
    end
    if (mode == 2) begin
      checks++;
      if (acks != 1) begin
        errors++; $display("FAIL double_write_acks: got %0d expected 1", acks);
      end
    end
    bus.div_wr = 1'b0; bus.en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_en_drop();
    int n, ticks;
    bit strobe;
    set_div(4, 0);
    bus.en = 1'b1; n = 0; ticks = 0;
    while (ticks < 9 && n < 1000) begin
      step(); n++;
      if (bus.os_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 9 || bus.bclk !== 1'b0) begin
      errors++; $display("FAIL en_drop_pre: got ticks=%0d bclk=%b expected 9/0", ticks, bus.bclk);
    end
    step();
    bus.en = 1'b0;
    strobe = 0;
    repeat (6) begin
      step();
      if (bus.os_tick !== 1'b0 || bus.baud_tick !== 1'b0 || bus.bclk !== 1'b1) strobe = 1;
    end
    checks++;
    if (strobe || bus.div_cur !== DIV_W'(4)) begin
      errors++; $display("FAIL en_drop_hold: got bad=%0d cur=%0d expected 0/4", strobe, bus.div_cur);
    end
    bus.en = 1'b1; n = 0;
    do begin step(); n++; end while (bus.baud_tick !== 1'b1 && n < 200);
    checks++;
    if (n != OS * 4) begin
      errors++; $display("FAIL en_resume_baud: got %0d expected %0d", n, OS * 4);
    end
    bus.en = 1'b0;
    step();
  endtask

`ifdef BAUD_FRAC_EN
  task automatic test_frac(input int f, input int tlen);
    int acc, nxt, sum;
    bit e_os;
    set_div(4, f);
    bus.div_frac_in = '0;
    bus.en = 1'b1; acc = 0; nxt = 4;
    for (int t = 1; t <= tlen; t++) begin
      step();
      e_os = (t == nxt);
      if (e_os) begin
        sum = acc + f;
        acc = sum % 256;
        nxt = t + 4 + sum / 256;
      end
      checks++;
      if (bus.os_tick !== e_os) begin
        errors++; $display("FAIL frac f=%0d t=%0d: got %b expected %b", f, t, bus.os_tick, e_os);
      end
    end
    bus.en = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_midrun();
    int n, acks;
    set_div(5, 0);
    bus.en = 1'b1;
    repeat (23) step();
    bus.div_wr = 1'b1; bus.div_in = DIV_W'(9);
    step();
    bus.div_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.div_cur !== DIV_W'(D_RST) || {bus.os_tick, bus.baud_tick, bus.div_ack, bus.bclk} !== 4'b0001) begin
      errors++; $display("FAIL async_reset: got cur=%0d os/bd/ack/bclk=%b%b%b%b expected %0d 0001",
                         bus.div_cur, bus.os_tick, bus.baud_tick, bus.div_ack, bus.bclk, D_RST);
    end
    repeat (2) step();
    checks++;
    if (bus.div_cur !== DIV_W'(D_RST) || {bus.os_tick, bus.baud_tick, bus.bclk} !== 3'b001) begin
      errors++; $display("FAIL reset_hold: got cur=%0d os/bd/bclk=%b%b%b", bus.div_cur,
                         bus.os_tick, bus.baud_tick, bus.bclk);
    end
    rst_n = 1'b1; n = 0; acks = 0;
    do begin
      step(); n++;
      if (bus.div_ack === 1'b1) acks++;
    end while (bus.os_tick !== 1'b1 && n < D_RST + 20);
    checks++;
    if (n != D_RST || acks != 0 || bus.div_cur !== DIV_W'(D_RST)) begin
      errors++; $display("FAIL reset_discard: got first=%0d acks=%0d cur=%0d expected %0d 0 %0d",
                         n, acks, bus.div_cur, D_RST, D_RST);
    end
    bus.en = 1'b0;
    step();
  endtask

  initial begin
    bus.en = 1'b0; bus.div_wr = 1'b0; bus.div_in = '0;
`ifdef BAUD_FRAC_EN
    bus.div_frac_in = '0;
`endif
    test_reset();
    test_default();
    test_fixed_div(4);
    test_fixed_div(0);
    repeat (3) test_fixed_div($urandom_range(2, 12));
    test_writes(1, 4, 30);
    test_writes(2, 4, 26);
    repeat (3) test_writes(0, $urandom_range(1, 8), 200);
    test_en_drop();
`ifdef BAUD_FRAC_EN
    test_frac(128, 60);
    test_frac($urandom_range(1, 255), 120);
`endif
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
